// File: rtl/demux_1_to_2_stream.sv
// demux_1_to_2_stream: registered 1-to-2 stream demux; s=1 steers d to x, s=0 to y,
// each side a one-entry valid/ready holding register with a delivered-word counter.
module demux_1_to_2_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    input  logic             s,
    output logic [WIDTH-1:0] x,
    output logic             x_valid,
    input  logic             x_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [CNT_W-1:0] x_count,
    output logic [CNT_W-1:0] y_count
);
    typedef enum logic {EMPTY, FULL} side_t;
    side_t x_state, x_next, y_state, y_next;
    logic  load_x, load_y, drain_x, drain_y;

    assign x_valid = x_state == FULL;
    assign y_valid = y_state == FULL;

    // A refill on the same edge as a drain keeps the side FULL.
    always_comb begin
        d_ready = s ? (!x_valid || x_ready) : (!y_valid || y_ready);
        load_x  = d_valid && d_ready && s;
        load_y  = d_valid && d_ready && !s;
        drain_x = x_valid && x_ready;
        drain_y = y_valid && y_ready;
        x_next  = load_x ? FULL : drain_x ? EMPTY : x_state;
        y_next  = load_y ? FULL : drain_y ? EMPTY : y_state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_state <= EMPTY;
            y_state <= EMPTY;
        end else begin
            x_state <= x_next;
            y_state <= y_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x       <= '0;
            y       <= '0;
            x_count <= '0;
            y_count <= '0;
        end else begin
            if (load_x) x <= d;
            if (load_y) y <= d;
            if (drain_x) x_count <= x_count + 1'b1;
            if (drain_y) y_count <= y_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_demux_1_to_2_stream.sv
// tb_demux_1_to_2_stream: directed and random stimulus against a queue-based reference model.
module tb_demux_1_to_2_stream;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int MODN  = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic             d_valid = 1'b0, s = 1'b0, x_ready = 1'b0, y_ready = 1'b0;
    logic             d_ready, x_valid, y_valid;
    logic [WIDTH-1:0] x, y;
    logic [CNT_W-1:0] x_count, y_count;

    int n_chk = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] qx[$], qy[$];
    logic [WIDTH-1:0] xl = '0, yl = '0;
    int               xc = 0, yc = 0;

    demux_1_to_2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .d(d), .d_valid(d_valid), .d_ready(d_ready), .s(s),
        .x(x), .x_valid(x_valid), .x_ready(x_ready),
        .y(y), .y_valid(y_valid), .y_ready(y_ready),
        .x_count(x_count), .y_count(y_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        qx.delete();
        qy.delete();
        xl = '0;
        yl = '0;
        xc = 0;
        yc = 0;
    endtask

    task automatic chk_outs();
        chk("x_valid", 32'(x_valid), 32'(qx.size() != 0));
        chk("y_valid", 32'(y_valid), 32'(qy.size() != 0));
        chk("x", 32'(x), 32'(xl));
        chk("y", 32'(y), 32'(yl));
        chk("x_count", 32'(x_count), 32'(xc));
        chk("y_count", 32'(y_count), 32'(yc));
    endtask

    function automatic logic exp_ready();
        return s ? (qx.size() == 0 || x_ready) : (qy.size() == 0 || y_ready);
    endfunction

    task automatic drive(input logic dv, input logic [WIDTH-1:0] dd, input logic ss,
                         input logic xr, input logic yr);
        d_valid = dv;
        d = dd;
        s = ss;
        x_ready = xr;
        y_ready = yr;
    endtask

    // One clock: check d_ready, predict transfers, advance model at the edge, check outputs.
    task automatic step();
        logic acc, ox, oy;
        #1;
        chk("d_ready", 32'(d_ready), 32'(exp_ready()));
        acc = d_valid && exp_ready();
        ox  = qx.size() != 0 && x_ready;
        oy  = qy.size() != 0 && y_ready;
        @(posedge clk);
        if (ox) begin
            void'(qx.pop_front());
            xc = (xc + 1) % MODN;
        end
        if (oy) begin
            void'(qy.pop_front());
            yc = (yc + 1) % MODN;
        end
        if (acc && s) begin
            qx.push_back(d);
            xl = d;
        end
        if (acc && !s) begin
            qy.push_back(d);
            yl = d;
        end
        #1;
        chk_outs();
    endtask

    initial begin
        model_clear();
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            @(posedge clk);
            #1;
            chk_outs();
        end
        s = 1'b1;
        #1 chk("rst_d_ready_s1", 32'(d_ready), 32'd1);
        s = 1'b0;
        #1 chk("rst_d_ready_s0", 32'(d_ready), 32'd1);
        reset_n = 1'b1;

        drive(1, 8'hA5, 1, 1, 1);
        step();
        chk("steer_x", 32'(x), 32'hA5);
        drive(1, 8'h3C, 0, 1, 1);
        step();
        chk("steer_y", 32'(y), 32'h3C);
        drive(0, 8'h00, 0, 1, 1);
        step();
        chk("steer_xcnt", 32'(x_count), 32'd1);
        chk("steer_ycnt", 32'(y_count), 32'd1);

        drive(1, 8'h11, 1, 0, 1);
        step();
        drive(0, 8'h00, 1, 0, 1);
        #1 chk("bp_ready_s1", 32'(d_ready), 32'd0);
        s = 1'b0;
        #1 chk("bp_ready_s0", 32'(d_ready), 32'd1);
        drive(1, 8'h22, 0, 0, 1);
        step();
        drive(0, 8'h00, 0, 0, 1);
        step();
        chk("bp_x_hold", 32'(x), 32'h11);
        drive(0, 8'h00, 0, 1, 1);
        step();
        chk("bp_x_drained", 32'(x_valid), 32'd0);

        for (int i = 1; i <= 16; i++) begin
            drive(1, 8'(i), 1, 1, 0);
            step();
            chk("tp_x", 32'(x), 32'(i));
        end
        drive(0, 8'h00, 1, 1, 0);
        step();

        drive(1, 8'h55, 0, 0, 0);
        step();
        drive(1, 8'h66, 0, 0, 0);
        #1 chk("sel_stall_ready", 32'(d_ready), 32'd0);
        s = 1'b1;
        step();
        chk("sel_x", 32'(x), 32'h66);
        chk("sel_y_kept", 32'(y), 32'h55);

        for (int i = 0; i < 17; i++) begin
            drive(1, 8'($urandom), 0, 1, 1);
            step();
        end

        drive(1, 8'h77, 1, 0, 0);
        step();
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        chk("arst_x_valid", 32'(x_valid), 32'd0);
        chk("arst_x_count", 32'(x_count), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
